hw_accel_pack_seq: RTL and testbench

Frame-level sequencer that sits in front of `hw_accel_pack_rgb_gray` in the hardware-accelerator datapath. It accepts one frame command (pixel count), then moves upstream pixels into the packer with a valid/ready handshake. It zero-pads the frame tail to a multiple of 4 pixels so the packer always completes its last word. It stalls on downstream almost-full, counts emitted 32-bit words and signals frame completion.

---
 rtl/hw_accel_pkg.sv | 32 +++
 rtl/hw_accel_pack_rgb_gray.sv | 81 ++++++++
 rtl/hw_accel_pack_seq.sv | 159 +++++++++++++++
 tb/tb_hw_accel_pack_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hw_accel_pkg.sv
// Shared definitions for the hardware-accelerator packing datapath:
// sequencer state encoding, packer mode codes and frame sizing helpers.
package hw_accel_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_STREAM = 3'd1;
   localparam logic [2:0] ST_PAD    = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam int MODE_RGB  = 0;
   localparam int MODE_BGR  = 1;
   localparam int MODE_GRAY = 2;

   // Round a pixel count up to the next multiple of four pixels.
   function automatic logic [31:0] roundUpToQuad(input logic [31:0] pixels);
      return (pixels + 32'd3) & ~32'd3;
   endfunction

   // Number of 32-bit words the packer emits for a padded frame:
   // three bytes per RGB pixel, one byte per grayscale pixel.
   function automatic logic [31:0] calcExpectedWords(input logic [31:0] paddedPixels,
                                                     input int          mode);
      logic [31:0] quads;
      quads = paddedPixels >> 2;
      if (mode == MODE_GRAY) begin
         return quads;
      end
      return (quads << 1) + quads;
   endfunction

endpackage

// File: rtl/hw_accel_pack_rgb_gray.sv
// Byte packer: turns a stream of RGB888 or grayscale pixels into
// little-endian 32-bit words (first byte in bits 7:0). One cycle latency
// from an accepted pixel to the word it completes.
module hw_accel_pack_rgb_gray
   import hw_accel_pkg::*;
#(
   parameter int PACK_MODE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [23:0] in_rgb,
   input  logic [7:0]  in_gray,
   output logic        out_valid,
   output logic [31:0] out_data
);

   logic [23:0] accQ, accD;
   logic [1:0]  packCountQ, packCountD;
   logic        outValidQ, outValidD;
   logic [31:0] outDataQ, outDataD;

   logic [23:0] pixelBytes;
   logic [2:0]  bytesPerPixel;
   logic [2:0]  byteTotal;
   logic [4:0]  shiftAmt;
   logic [47:0] merged;

   // Order the incoming pixel's bytes so the first byte on the wire sits in the LSB.
   always_comb begin
      pixelBytes = {in_rgb[7:0], in_rgb[15:8], in_rgb[23:16]};
      case (PACK_MODE)
         MODE_BGR:  pixelBytes = in_rgb;
         MODE_GRAY: pixelBytes = {16'h0000, in_gray};
         default:   pixelBytes = {in_rgb[7:0], in_rgb[15:8], in_rgb[23:16]};
      endcase
   end

   assign bytesPerPixel = (PACK_MODE == MODE_GRAY) ? 3'd1 : 3'd3;
   assign byteTotal     = {1'b0, packCountQ} + bytesPerPixel;
   assign shiftAmt      = {packCountQ, 3'b000};
   assign merged        = {24'h000000, accQ} | ({24'h000000, pixelBytes} << shiftAmt);

   // Append the pixel's bytes to the leftover bytes and emit a word once four are held.
   always_comb begin
      accD       = accQ;
      packCountD = packCountQ;
      outValidD  = 1'b0;
      outDataD   = outDataQ;
      if (in_valid) begin
         if (byteTotal >= 3'd4) begin
            outValidD  = 1'b1;
            outDataD   = merged[31:0];
            accD       = {8'h00, merged[47:32]};
            packCountD = 2'(byteTotal - 3'd4);
         end else begin
            accD       = merged[23:0];
            packCountD = byteTotal[1:0];
         end
      end
   end

   // Packer registers; reset realigns the byte position to a word boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         accQ       <= '0;
         packCountQ <= '0;
         outValidQ  <= 1'b0;
         outDataQ   <= '0;
      end else begin
         accQ       <= accD;
         packCountQ <= packCountD;
         outValidQ  <= outValidD;
         outDataQ   <= outDataD;
      end
   end

   assign out_valid = outValidQ;
   assign out_data  = outDataQ;

endmodule

// File: rtl/hw_accel_pack_seq.sv
// Frame sequencer in front of the byte packer: takes a pixel-count command,
// streams upstream pixels into the packer, zero-pads the tail to a multiple
// of four pixels, counts emitted words and pulses done at frame end.
module hw_accel_pack_seq
   import hw_accel_pkg::*;
#(
   parameter int PACK_MODE = 0,
   parameter int CNT_W     = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic [CNT_W-1:0] cfg_pixel_count,
   output logic             cfg_busy,
   output logic             cfg_done,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [23:0]      s_rgb,
   input  logic [7:0]       s_gray,
   input  logic             m_afull,
   output logic [31:0]      m_data,
   output logic             m_valid,
   output logic [CNT_W-1:0] word_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [2:0]       stateQ, stateD;
   logic [CNT_W-1:0] pixelTargetQ, pixelTargetD;
   logic [CNT_W-1:0] paddedTargetQ, paddedTargetD;
   logic [CNT_W-1:0] expectedWordsQ, expectedWordsD;
   logic [CNT_W-1:0] pixelCountQ, pixelCountD;
   logic [CNT_W-1:0] wordCountQ, wordCountD;
   logic             packValidQ, packValidD;
   logic [23:0]      packRgbQ, packRgbD;
   logic [7:0]       packGrayQ, packGrayD;

   logic [CNT_W-1:0] paddedStart;
   logic [CNT_W-1:0] expectedStart;
   logic [CNT_W-1:0] pixelCountInc;
   logic [CNT_W-1:0] wordCountNext;
   logic             transfer;
   logic             countWord;

   assign paddedStart   = CNT_W'(roundUpToQuad(32'(cfg_pixel_count)));
   assign expectedStart = CNT_W'(calcExpectedWords(32'(paddedStart), PACK_MODE));
   assign pixelCountInc = pixelCountQ + CNT_ONE;

   assign s_ready  = (stateQ == ST_STREAM) && !m_afull;
   assign transfer = s_valid && s_ready;

   // Words beyond the expected total are a protocol error and leave the count saturated.
   assign countWord     = m_valid && (wordCountQ != expectedWordsQ);
   assign wordCountNext = countWord ? (wordCountQ + CNT_ONE) : wordCountQ;

   // Frame FSM: command capture, streaming, tail padding, drain and completion.
   always_comb begin
      stateD         = stateQ;
      pixelTargetD   = pixelTargetQ;
      paddedTargetD  = paddedTargetQ;
      expectedWordsD = expectedWordsQ;
      pixelCountD    = pixelCountQ;
      wordCountD     = wordCountQ;
      packValidD     = 1'b0;
      packRgbD       = packRgbQ;
      packGrayD      = packGrayQ;
      case (stateQ)
         ST_IDLE: begin
            if (cfg_start) begin
               pixelTargetD   = cfg_pixel_count;
               paddedTargetD  = paddedStart;
               expectedWordsD = expectedStart;
               pixelCountD    = '0;
               wordCountD     = '0;
               // An empty frame still passes through DRAIN so it completes like any other.
               stateD         = (cfg_pixel_count == '0) ? ST_DRAIN : ST_STREAM;
            end
         end
         ST_STREAM: begin
            wordCountD = wordCountNext;
            if (transfer) begin
               packValidD  = 1'b1;
               packRgbD    = s_rgb;
               packGrayD   = s_gray;
               pixelCountD = pixelCountInc;
               if (pixelCountInc == pixelTargetQ) begin
                  stateD = (pixelTargetQ[1:0] != 2'b00) ? ST_PAD : ST_DRAIN;
               end
            end
         end
         ST_PAD: begin
            wordCountD = wordCountNext;
            if (!m_afull) begin
               packValidD  = 1'b1;
               packRgbD    = '0;
               packGrayD   = '0;
               pixelCountD = pixelCountInc;
               if (pixelCountInc == paddedTargetQ) begin
                  stateD = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            wordCountD = wordCountNext;
            if (wordCountNext == expectedWordsQ) begin
               stateD = ST_DONE;
            end
         end
         ST_DONE: begin
            stateD = ST_IDLE;
         end
         default: begin
            stateD = ST_IDLE;
         end
      endcase
   end

   // Sequencer registers, including the registered packer input stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ         <= ST_IDLE;
         pixelTargetQ   <= '0;
         paddedTargetQ  <= '0;
         expectedWordsQ <= '0;
         pixelCountQ    <= '0;
         wordCountQ     <= '0;
         packValidQ     <= 1'b0;
         packRgbQ       <= '0;
         packGrayQ      <= '0;
      end else begin
         stateQ         <= stateD;
         pixelTargetQ   <= pixelTargetD;
         paddedTargetQ  <= paddedTargetD;
         expectedWordsQ <= expectedWordsD;
         pixelCountQ    <= pixelCountD;
         wordCountQ     <= wordCountD;
         packValidQ     <= packValidD;
         packRgbQ       <= packRgbD;
         packGrayQ      <= packGrayD;
      end
   end

   assign cfg_busy   = (stateQ == ST_STREAM) || (stateQ == ST_PAD) || (stateQ == ST_DRAIN);
   assign cfg_done   = (stateQ == ST_DONE);
   assign word_count = wordCountQ;

   hw_accel_pack_rgb_gray #(
      .PACK_MODE (PACK_MODE)
   ) u_pack (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (packValidQ),
      .in_rgb    (packRgbQ),
      .in_gray   (packGrayQ),
      .out_valid (m_valid),
      .out_data  (m_data)
   );

endmodule

// File: tb/tb_hw_accel_pack_seq.sv
// Self-checking bench: three sequencers (RGB, BGR, gray) run in lockstep on
// shared stimulus; a byte-stream reference model fills per-mode scoreboards
// that a negedge monitor drains whenever a packed word appears.
module tb_hw_accel_pack_seq;

   localparam int CNT_W = 20;

   logic             clk;
   logic             rst;
   logic             cfg_start;
   logic [CNT_W-1:0] cfg_pixel_count;
   logic             s_valid;
   logic [23:0]      s_rgb;
   logic [7:0]       s_gray;
   logic             m_afull;

   logic [2:0]       cfgBusy;
   logic [2:0]       cfgDone;
   logic [2:0]       sReady;
   logic [2:0]       mValid;
   logic [31:0]      mData [3];
   logic [CNT_W-1:0] wordCount [3];

   logic [31:0] expQ0[$];
   logic [31:0] expQ1[$];
   logic [31:0] expQ2[$];
   int          expE [3];
   int          lastValidCycle [3];

   int checks = 0;
   int failures = 0;
   int cycle = 0;
   int doneSeen = 0;
   bit doneExpected = 0;
   int frameN = 0;
   int startCycle = 0;

   hw_accel_pack_seq #(.PACK_MODE(0), .CNT_W(CNT_W)) dutRgb (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_pixel_count(cfg_pixel_count),
      .cfg_busy(cfgBusy[0]), .cfg_done(cfgDone[0]), .s_valid(s_valid), .s_ready(sReady[0]),
      .s_rgb(s_rgb), .s_gray(s_gray), .m_afull(m_afull), .m_data(mData[0]),
      .m_valid(mValid[0]), .word_count(wordCount[0]));

   hw_accel_pack_seq #(.PACK_MODE(1), .CNT_W(CNT_W)) dutBgr (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_pixel_count(cfg_pixel_count),
      .cfg_busy(cfgBusy[1]), .cfg_done(cfgDone[1]), .s_valid(s_valid), .s_ready(sReady[1]),
      .s_rgb(s_rgb), .s_gray(s_gray), .m_afull(m_afull), .m_data(mData[1]),
      .m_valid(mValid[1]), .word_count(wordCount[1]));

   hw_accel_pack_seq #(.PACK_MODE(2), .CNT_W(CNT_W)) dutGray (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_pixel_count(cfg_pixel_count),
      .cfg_busy(cfgBusy[2]), .cfg_done(cfgDone[2]), .s_valid(s_valid), .s_ready(sReady[2]),
      .s_rgb(s_rgb), .s_gray(s_gray), .m_afull(m_afull), .m_data(mData[2]),
      .m_valid(mValid[2]), .word_count(wordCount[2]));

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to time-stamp words and done pulses
   always @(posedge clk) begin
      cycle <= cycle + 1;
   end

   // Single comparison point: every check goes through here
   task automatic compare(input string name, input int mode, input logic [31:0] act,
                          input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s mode%0d: got 0x%0h expected 0x%0h (cycle %0d)",
                  name, mode, act, exp, cycle);
      end
   endtask

   // Pop the expected word for a mode and compare it with the DUT word
   task automatic checkOutput(input int k);
      logic [31:0] exp;
      int          sz;
      case (k)
         0:       sz = expQ0.size();
         1:       sz = expQ1.size();
         default: sz = expQ2.size();
      endcase
      if (sz == 0) begin
         compare("unexpected_word", k, 32'd1, 32'd0);
      end else begin
         case (k)
            0:       exp = expQ0.pop_front();
            1:       exp = expQ1.pop_front();
            default: exp = expQ2.pop_front();
         endcase
         compare("word_data", k, mData[k], exp);
      end
   endtask

   // Check a done pulse: expected at all, final word count, busy dropped, timing
   task automatic checkDone(input int k);
      compare("done_expected", k, 32'(doneExpected), 32'd1);
      compare("done_word_count", k, 32'(wordCount[k]), 32'(expE[k]));
      compare("done_busy_low", k, 32'(cfgBusy[k]), 32'd0);
      if (frameN > 0) begin
         compare("done_after_last_word", k, 32'(cycle), 32'(lastValidCycle[k] + 1));
      end else begin
         compare("done_empty_frame_time", k, 32'(cycle), 32'(startCycle + 2));
      end
   endtask

   // Monitor: consumes scoreboard entries whenever a word or done is presented
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            if (mValid[k]) begin
               checkOutput(k);
               lastValidCycle[k] = cycle;
            end
            if (cfgDone[k]) begin
               checkDone(k);
            end
         end
         if (cfgDone[0]) begin
            doneSeen++;
            doneExpected = 0;
         end
      end
   end

   // All observable outputs at their idle/reset values
   task automatic checkResetValues(input string tag);
      for (int k = 0; k < 3; k++) begin
         compare({tag, "_busy"}, k, 32'(cfgBusy[k]), 32'd0);
         compare({tag, "_done"}, k, 32'(cfgDone[k]), 32'd0);
         compare({tag, "_ready"}, k, 32'(sReady[k]), 32'd0);
         compare({tag, "_mvalid"}, k, 32'(mValid[k]), 32'd0);
         compare({tag, "_mdata"}, k, mData[k], 32'd0);
         compare({tag, "_word_count"}, k, 32'(wordCount[k]), 32'd0);
      end
   endtask

   // Run one frame: build the expected words from the byte-stream model, issue the
   // command, feed pixels with random gaps/stalls, optionally re-pulse start or abort.
   task automatic applyStimulus(input int n, input int validPct, input int afullPct,
                                input bit grayPattern, input int restartAt,
                                input int stallStart, input int stallLen, input int abortAt);
      logic [23:0] rgbArr[$];
      logic [7:0]  grayArr[$];
      logic [7:0]  bytes0[$];
      logic [7:0]  bytes1[$];
      logic [7:0]  bytes2[$];
      logic [31:0] r;
      logic [23:0] px;
      logic [7:0]  g;
      int          padded;
      int          idx;
      int          guard;
      int          base;
      bit          fire;

      for (int i = 0; i < n; i++) begin
         r = $urandom();
         rgbArr.push_back(r[23:0]);
         if (grayPattern) begin
            grayArr.push_back(8'((i + 1) * 17));
         end else begin
            grayArr.push_back(r[31:24]);
         end
      end

      padded = ((n + 3) / 4) * 4;
      for (int i = 0; i < padded; i++) begin
         px = (i < n) ? rgbArr[i] : 24'h0;
         g  = (i < n) ? grayArr[i] : 8'h0;
         bytes0.push_back(px[23:16]); bytes0.push_back(px[15:8]); bytes0.push_back(px[7:0]);
         bytes1.push_back(px[7:0]);   bytes1.push_back(px[15:8]); bytes1.push_back(px[23:16]);
         bytes2.push_back(g);
      end
      for (int w = 0; w < bytes0.size() / 4; w++) begin
         expQ0.push_back({bytes0[4*w+3], bytes0[4*w+2], bytes0[4*w+1], bytes0[4*w]});
         expQ1.push_back({bytes1[4*w+3], bytes1[4*w+2], bytes1[4*w+1], bytes1[4*w]});
      end
      for (int w = 0; w < bytes2.size() / 4; w++) begin
         expQ2.push_back({bytes2[4*w+3], bytes2[4*w+2], bytes2[4*w+1], bytes2[4*w]});
      end
      expE[0] = bytes0.size() / 4;
      expE[1] = bytes1.size() / 4;
      expE[2] = bytes2.size() / 4;

      base         = doneSeen;
      doneExpected = 1;
      frameN       = n;

      @(negedge clk); #1;
      cfg_start       = 1'b1;
      cfg_pixel_count = CNT_W'(n);
      startCycle      = cycle;
      @(negedge clk); #1;
      cfg_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         compare("busy_after_start", k, 32'(cfgBusy[k]), 32'd1);
      end

      idx   = 0;
      guard = 0;
      while (doneSeen == base && guard < 2000) begin
         if (guard == abortAt) begin
            rst       = 1'b1;
            s_valid   = 1'b0;
            cfg_start = 1'b0;
            m_afull   = 1'b0;
            @(posedge clk);
            expQ0.delete(); expQ1.delete(); expQ2.delete();
            doneExpected = 0;
            @(negedge clk); #1;
            checkResetValues("abort");
            rst = 1'b0;
            return;
         end
         cfg_start       = (guard == restartAt);
         cfg_pixel_count = CNT_W'((guard == restartAt) ? n + 7 : n);
         s_valid = (idx < n) && ($urandom_range(1, 100) <= validPct);
         s_rgb   = (idx < n) ? rgbArr[idx] : 24'h0;
         s_gray  = (idx < n) ? grayArr[idx] : 8'h0;
         m_afull = (guard >= stallStart && guard < stallStart + stallLen) ||
                   ($urandom_range(1, 100) <= afullPct);
         #1;
         fire = s_valid && sReady[0];
         @(posedge clk);
         if (fire) idx++;
         @(negedge clk); #1;
         guard++;
      end
      s_valid   = 1'b0;
      m_afull   = 1'b0;
      cfg_start = 1'b0;

      if (doneSeen == base) begin
         compare("frame_timeout", 0, 32'(guard), 32'd0);
      end
      compare("pixels_consumed", 0, 32'(idx), 32'(n));
      repeat (3) @(negedge clk);
      #1;
      compare("single_done", 0, 32'(doneSeen), 32'(base + 1));
      compare("queue_empty", 0, 32'(expQ0.size()), 32'd0);
      compare("queue_empty", 1, 32'(expQ1.size()), 32'd0);
      compare("queue_empty", 2, 32'(expQ2.size()), 32'd0);
   endtask

   // Directed frames from the test plan followed by randomized frames
   initial begin
      rst             = 1'b1;
      cfg_start       = 1'b0;
      cfg_pixel_count = '0;
      s_valid         = 1'b0;
      s_rgb           = '0;
      s_gray          = '0;
      m_afull         = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkResetValues("reset");
      rst = 1'b0;

      applyStimulus(8, 100, 0, 1'b0, -1, -1, 0, -1);
      applyStimulus(5, 100, 0, 1'b1, -1, -1, 0, -1);
      applyStimulus(4, 100, 0, 1'b0, -1, 2, 5, -1);
      applyStimulus(9, 100, 0, 1'b0, 3, -1, 0, -1);
      applyStimulus(12, 100, 0, 1'b0, -1, -1, 0, 4);
      repeat (6) @(negedge clk);
      applyStimulus(4, 100, 0, 1'b0, -1, -1, 0, -1);
      applyStimulus(0, 100, 0, 1'b0, -1, -1, 0, -1);
      applyStimulus(3, 100, 0, 1'b0, -1, -1, 0, -1);

      for (int f = 0; f < 10; f++) begin
         applyStimulus($urandom_range(1, 14), $urandom_range(50, 100), $urandom_range(0, 30),
                       1'b0, -1, -1, 0, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
